// File: rtl/ysyx_22050710_pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, offers it to the fetch stage and applies
// exception/branch redirects. It counts accepted fetches and stops for good on ebreak.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | first cycle after reset, nothing offered to fetch
// ST_RUN  | PC offered each cycle, redirects and increments applied
// ST_HALT | ebreak retired, fetch stopped and PC frozen until reset
module ysyx_22050710_pre_if_stage #(
    parameter int               PC_WD  = 64,
    parameter logic [PC_WD-1:0] RST_PC = PC_WD'(64'h0000_0000_8000_0000)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fs_allowin,
    input  logic             i_redirect_valid,
    input  logic [PC_WD-1:0] i_redirect_target,
    input  logic             i_exc_valid,
    input  logic [PC_WD-1:0] i_exc_target,
    input  logic             i_halt,
    output logic             o_to_fs_valid,
    output logic [PC_WD-1:0] o_fs_pc,
    output logic [63:0]      o_fetch_cnt,
    output logic             o_halted
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]       state;
    logic [PC_WD-1:0] fetch_pc;
    logic [63:0]      fetch_cnt;
    logic             in_run;
    logic             transfer;

    assign in_run = (state == ST_RUN);

    // The PC on the wrong path is squashed in the cycle that a redirect or halt arrives.
    assign o_to_fs_valid = in_run & ~i_exc_valid & ~i_redirect_valid & ~i_halt;
    assign transfer      = o_to_fs_valid & i_fs_allowin;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_BOOT;
            fetch_pc  <= RST_PC;
            fetch_cnt <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= i_halt ? ST_HALT : ST_RUN;
                ST_RUN:  if (i_halt) state <= ST_HALT;
                default: state <= ST_HALT;
            endcase

            // A redirect still loads when halt arrives with it, so debug can read the target.
            if (in_run) begin
                if (i_exc_valid)
                    fetch_pc <= i_exc_target;
                else if (i_redirect_valid)
                    fetch_pc <= i_redirect_target;
                else if (transfer)
                    fetch_pc <= fetch_pc + PC_WD'(4);
            end

            if (transfer)
                fetch_cnt <= fetch_cnt + 64'd1;
        end
    end

    assign o_fs_pc     = fetch_pc;
    assign o_fetch_cnt = fetch_cnt;
    assign o_halted    = (state == ST_HALT);

endmodule

// File: tb/tb_ysyx_22050710_pre_if_stage.sv
// Bench for the pre-IF stage. It uses directed scenarios and a random run, and checks
// them against a small behavioural model of the fetch-PC rules.
module tb_ysyx_22050710_pre_if_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        allowin;
    logic        rv;
    logic [63:0] rt;
    logic        ev;
    logic [63:0] et;
    logic        halt;
    logic        valid;
    logic [63:0] pc;
    logic [63:0] cnt;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: where the core is in its life and what it has fetched.
    bit          m_booting;
    bit          m_stopped;
    logic [63:0] m_pc;
    logic [63:0] m_cnt;

    ysyx_22050710_pre_if_stage dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_fs_allowin      (allowin),
        .i_redirect_valid  (rv),
        .i_redirect_target (rt),
        .i_exc_valid       (ev),
        .i_exc_target      (et),
        .i_halt            (halt),
        .o_to_fs_valid     (valid),
        .o_fs_pc           (pc),
        .o_fetch_cnt       (cnt),
        .o_halted          (halted)
    );

    always #5 clk = ~clk;

    function automatic bit m_valid();
        return !m_booting && !m_stopped && !ev && !rv && !halt;
    endfunction

    task automatic set_in(input bit a, input bit r, input logic [63:0] rtg,
                          input bit e, input logic [63:0] etg, input bit h);
        allowin = a; rv = r; rt = rtg; ev = e; et = etg; halt = h;
        #1;
    endtask

    // Advance one clock, update the model from the inputs that were applied,
    // and leave the bench 1 time unit after the next falling edge.
    task automatic tick();
        bit v;
        v = m_valid();
        @(posedge clk);
        if (rst) begin
            m_booting = 1; m_stopped = 0; m_pc = RST_PC; m_cnt = 0;
        end else if (m_booting) begin
            m_booting = 0;
            m_stopped = halt;
        end else if (!m_stopped) begin
            if (ev)                m_pc = et;
            else if (rv)           m_pc = rt;
            else if (v && allowin) m_pc = m_pc + 64'd4;
            if (v && allowin) m_cnt = m_cnt + 64'd1;
            if (halt) m_stopped = 1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        set_in(1, 1, 64'h1234, 1, 64'h5678, 0);
        tick(); tick();
        n_total++; if (pc !== RST_PC) $display("FAIL reset_pc got %h want %h", pc, RST_PC); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_total++; if (cnt !== 64'd0) $display("FAIL reset_cnt got %0d want 0", cnt); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
    endtask

    task automatic test_boot();
        logic [63:0] exp_pc [4];
        bit          exp_v  [4];
        exp_pc = '{64'h8000_0000, 64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
        exp_v  = '{1'b0, 1'b1, 1'b1, 1'b1};
        rst = 0;
        set_in(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (valid !== exp_v[i] || pc !== exp_pc[i])
                $display("FAIL boot_cycle%0d got valid=%b pc=%h want valid=%b pc=%h", i + 1, valid, pc, exp_v[i], exp_pc[i]);
            else n_pass++;
            tick();
        end
        n_total++; if (cnt !== 64'd3) $display("FAIL boot_cnt got %0d want 3", cnt); else n_pass++;
    endtask

    task automatic test_stall();
        tick();
        n_total++; if (pc !== 64'h8000_0010 || valid !== 1'b1) $display("FAIL stall_setup got pc=%h valid=%b want 80000010/1", pc, valid); else n_pass++;
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (pc !== 64'h8000_0010 || cnt !== 64'd4 || valid !== 1'b1)
                $display("FAIL stall_hold%0d got pc=%h cnt=%0d valid=%b want 80000010/4/1", i, pc, cnt, valid);
            else n_pass++;
        end
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        n_total++; if (pc !== 64'h8000_0014 || cnt !== 64'd5) $display("FAIL stall_release got pc=%h cnt=%0d want 80000014/5", pc, cnt); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        set_in(0, 1, 64'h8000_1000, 0, 0, 0);
        n_total++; if (valid !== 1'b0) $display("FAIL redir_squash got valid=%b want 0", valid); else n_pass++;
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_total++; if (pc !== 64'h8000_1000 || valid !== 1'b1) $display("FAIL redir_load got pc=%h valid=%b want 80001000/1", pc, valid); else n_pass++;
    endtask

    task automatic test_priority();
        set_in(1, 1, 64'h8000_2000, 1, 64'h8000_0100, 0);
        n_total++; if (valid !== 1'b0) $display("FAIL prio_squash got valid=%b want 0", valid); else n_pass++;
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_total++; if (pc !== 64'h8000_0100) $display("FAIL prio_pc got %h want 80000100", pc); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [63:0] c0;
        c0 = m_cnt;
        set_in(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        n_total++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || valid !== 1'b1) $display("FAIL wrap_setup got pc=%h valid=%b", pc, valid); else n_pass++;
        tick();
        n_total++; if (pc !== 64'd0 || cnt !== c0 + 64'd1) $display("FAIL wrap_pc got pc=%h cnt=%0d want 0/%0d", pc, cnt, c0 + 64'd1); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                   {$urandom, $urandom}, $urandom_range(0, 11) == 0,
                   {$urandom, $urandom}, 1'b0);
            n_total++;
            if (valid !== m_valid() || pc !== m_pc || cnt !== m_cnt || halted !== 1'b0)
                $display("FAIL rand_%0d got v=%b pc=%h cnt=%0d h=%b want v=%b pc=%h cnt=%0d h=0",
                         i, valid, pc, cnt, halted, m_valid(), m_pc, m_cnt);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_halt_reset();
        logic [63:0] c0;
        set_in(1, 1, 64'h8000_3000, 0, 0, 1);
        n_total++; if (valid !== 1'b0) $display("FAIL halt_squash got valid=%b want 0", valid); else n_pass++;
        tick();
        c0 = m_cnt;
        n_total++; if (halted !== 1'b1 || pc !== 64'h8000_3000) $display("FAIL halt_enter got h=%b pc=%h want 1/80003000", halted, pc); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            set_in(1, i[0], 64'h9000_0000, i[1], 64'hA000_0000, 0);
            n_total++;
            if (valid !== 1'b0 || halted !== 1'b1 || pc !== 64'h8000_3000 || cnt !== c0)
                $display("FAIL halt_sticky%0d got v=%b h=%b pc=%h cnt=%0d", i, valid, halted, pc, cnt);
            else n_pass++;
            tick();
        end
        rst = 1;
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
        n_total++;
        if (pc !== RST_PC || cnt !== 64'd0 || halted !== 1'b0 || valid !== 1'b0)
            $display("FAIL halt_reset got pc=%h cnt=%0d h=%b v=%b", pc, cnt, halted, valid);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (valid !== m_valid() || pc !== m_pc) $display("FAIL reboot%0d got v=%b pc=%h want v=%b pc=%h", i, valid, pc, m_valid(), m_pc);
            else n_pass++;
            tick();
        end
        n_total++; if (cnt !== 64'd3) $display("FAIL reboot_cnt got %0d want 3", cnt); else n_pass++;
    endtask

    task automatic test_boot_halt();
        rst = 1;
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
        set_in(1, 1, 64'h8000_4000, 0, 0, 1);
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        n_total++;
        if (halted !== 1'b1 || valid !== 1'b0 || pc !== RST_PC)
            $display("FAIL boot_halt got h=%b v=%b pc=%h want 1/0/%h", halted, valid, pc, RST_PC);
        else n_pass++;
    endtask

    initial begin
        m_booting = 1; m_stopped = 0; m_pc = RST_PC; m_cnt = 0;
        rst = 1;
        allowin = 0; rv = 0; rt = 0; ev = 0; et = 0; halt = 0;
        @(negedge clk);
        #1;
        test_reset();
        test_boot();
        test_stall();
        test_redirect_stall();
        test_priority();
        test_wrap();
        test_random();
        test_halt_reset();
        test_boot_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_pre_if_stage.md
YSYX_22050710_PRE_IF_STAGE -- requirements
Module: ysyx_22050710_pre_if_stage

Interface
REQ-001 The block SHALL have parameter: PC_WD, 64, PC/address width.
REQ-002 The block SHALL have parameter: RST_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-003 The block SHALL have port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port: i_fs_allowin  input  1  fetch stage can accept a PC this cycle.
REQ-006 The block SHALL have port: i_redirect_valid  input  1  branch/jump redirect from ID/EX, one-cycle pulse.
REQ-007 The block SHALL have port: i_redirect_target  input  PC_WD  redirect target PC.
REQ-008 The block SHALL have port: i_exc_valid  input  1  trap/mret redirect from WB, one-cycle pulse.
REQ-009 The block SHALL have port: i_exc_target  input  PC_WD  trap vector or mepc.
REQ-010 The block SHALL have port: i_halt  input  1  ebreak retired; stop fetching.
REQ-011 The block SHALL have port: o_to_fs_valid  output  1  PC offered to fetch stage (drives fetch sram enable).
REQ-012 The block SHALL have port: o_fs_pc  output  PC_WD  PC offered to fetch stage (drives fetch sram address and word select via bit 2).
REQ-013 The block SHALL have port: o_fetch_cnt  output  64  count of accepted fetches.
REQ-014 The block SHALL have port: o_halted  output  1  block is in HALT state.

Function
REQ-015 The block SHALL implement a state machine with states BOOT, RUN, HALT; encoding is free.
REQ-016 BOOT: o_to_fs_valid=0; on the next cycle the state SHALL advance to RUN unconditionally, unless i_halt is asserted, in which case it SHALL go to HALT.
REQ-017 RUN -> HALT when i_halt=1; HALT is sticky until reset; in HALT o_to_fs_valid=0, o_halted=1 and fetch_pc frozen.
REQ-018 Internal register fetch_pc SHALL drive o_fs_pc directly (registered output, no combinational path from inputs).
REQ-019 In RUN, o_to_fs_valid SHALL equal ~i_exc_valid & ~i_redirect_valid & ~i_halt (wrong-path PC squashed in the redirect cycle).
REQ-020 Transfer SHALL occur iff o_to_fs_valid=1 and i_fs_allowin=1.
REQ-021 fetch_pc update priority, evaluated each cycle in RUN: i_exc_valid -> i_exc_target; else i_redirect_valid -> i_redirect_target; else transfer -> fetch_pc+4; else hold.
REQ-022 Redirects SHALL load fetch_pc regardless of i_fs_allowin; no pending-redirect storage is required.
REQ-023 With no transfer and no redirect, fetch_pc and o_to_fs_valid SHALL remain stable (valid-hold rule).
REQ-024 fetch_pc+4 SHALL be modulo 2^PC_WD (wrap to 0 from all-ones minus 3).
REQ-025 Target PCs SHALL be loaded unmodified; alignment checking is out of scope.
REQ-026 Simultaneous i_exc_valid and i_redirect_valid SHALL select the exception target.
REQ-027 i_halt with a simultaneous redirect SHALL enter HALT; fetch_pc SHALL take the redirect target (for debug readout).
REQ-028 o_fetch_cnt SHALL increment by 1 on each transfer, wrapping at 2^64.
REQ-029 Redirect and exception inputs SHALL be ignored in BOOT and HALT.

Reset
REQ-030 While i_rst=1 the block SHALL be in BOOT with fetch_pc=RST_PC, o_to_fs_valid=0, o_fetch_cnt=0, o_halted=0.
REQ-031 Reset asserted mid-operation (any state, including HALT) SHALL reach these values at the next rising edge, overriding all other inputs.

Verification
REQ-032 Boot: release reset with i_fs_allowin=1 -> cycle 1 valid=0 and pc=0x80000000; cycles 2,3,4 valid=1 with pc=0x80000000, 0x80000004, 0x80000008; o_fetch_cnt=3 after cycle 4.
REQ-033 Stall: valid=1 and pc=0x80000010, hold i_fs_allowin=0 for 3 cycles -> pc stays 0x80000010 and o_fetch_cnt is unchanged; on release -> next pc=0x80000014.
REQ-034 Redirect during stall: i_fs_allowin=0, pulse redirect to 0x80001000 -> o_to_fs_valid=0 that cycle; next cycle pc=0x80001000 and valid=1.
REQ-035 Priority: same-cycle exc to 0x80000100 and redirect to 0x80002000 -> pc=0x80000100.
REQ-036 Halt and reset: pulse i_halt -> valid=0 and o_halted=1 persist through redirect pulses; then i_rst for 1 cycle -> pc=0x80000000, cnt=0 and boot sequence repeats.
REQ-037 Wrap: redirect to 0xFFFFFFFF_FFFFFFFC, accept once -> pc=0x0.
